// File: rtl/alu_muldiv.sv
// alu_muldiv -- execute-stage ALU with a sequential multiply/divide unit.
//
// Single-cycle operations produce ALU_result/zero/overflow combinationally.
// MULT/MULTU/DIV/DIVU run on a shared shift-add / restoring-divide datapath
// that takes WIDTH+1 busy cycles, then writes HI/LO and pulses done.
//
// Parameters:
//   WIDTH  datapath width (even, >= 8)
//   OPW    width of alu_control_out
//
// Ports:
//   clk              rising-edge clock
//   reset            asynchronous active-high reset
//   alu_control_out  operation code
//   read_data1       operand A (rs)
//   read_data2       operand B (rt or immediate)
//   start            launches a multiply/divide, sampled on the clk edge
//   ALU_result       combinational result
//   zero             branch condition / zero flag
//   overflow         signed overflow for ADD/SUB/ADDI/SUBI
//   busy             multiply/divide in progress
//   done             one-cycle pulse after HI/LO update
//   hi_out, lo_out   HI and LO registers
//
// Build option:
//   ALU_MTHILO_EN    when defined, MTHI (011111) and MTLO (100000) load HI/LO
//                    from operand A while the unit is idle.
//
// state | meaning
// ------+--------------------------------------------------------------
// IDLE  | waiting for start with a multiply/divide code
// RUN   | one multiply or divide step per cycle, WIDTH cycles
// FIX   | sign correction, HI/LO written on the exiting edge

module alu_muldiv #(
    parameter int WIDTH = 32,
    parameter int OPW   = 6
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [OPW-1:0]   alu_control_out,
    input  logic [WIDTH-1:0] read_data1,
    input  logic [WIDTH-1:0] read_data2,
    input  logic             start,
    output logic [WIDTH-1:0] ALU_result,
    output logic             zero,
    output logic             overflow,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi_out,
    output logic [WIDTH-1:0] lo_out
);

    localparam int SHW = $clog2(WIDTH);
    localparam int CW  = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    localparam logic [OPW-1:0] OP_ADD   = OPW'(6'b000000);
    localparam logic [OPW-1:0] OP_SUB   = OPW'(6'b000001);
    localparam logic [OPW-1:0] OP_AND   = OPW'(6'b000010);
    localparam logic [OPW-1:0] OP_NOR   = OPW'(6'b000011);
    localparam logic [OPW-1:0] OP_OR    = OPW'(6'b000100);
    localparam logic [OPW-1:0] OP_SLT   = OPW'(6'b000101);
    localparam logic [OPW-1:0] OP_ADDI  = OPW'(6'b000110);
    localparam logic [OPW-1:0] OP_ANDI  = OPW'(6'b000111);
    localparam logic [OPW-1:0] OP_SUBI  = OPW'(6'b001000);
    localparam logic [OPW-1:0] OP_ORI   = OPW'(6'b001001);
    localparam logic [OPW-1:0] OP_BEQ   = OPW'(6'b001010);
    localparam logic [OPW-1:0] OP_BNE   = OPW'(6'b001011);
    localparam logic [OPW-1:0] OP_BGEZ  = OPW'(6'b001100);
    localparam logic [OPW-1:0] OP_SLTI  = OPW'(6'b001101);
    localparam logic [OPW-1:0] OP_LH    = OPW'(6'b001110);
    localparam logic [OPW-1:0] OP_LW    = OPW'(6'b001111);
    localparam logic [OPW-1:0] OP_LUI   = OPW'(6'b010011);
    localparam logic [OPW-1:0] OP_LB    = OPW'(6'b010100);
    localparam logic [OPW-1:0] OP_SLTU  = OPW'(6'b010101);
    localparam logic [OPW-1:0] OP_SLL   = OPW'(6'b010110);
    localparam logic [OPW-1:0] OP_SRL   = OPW'(6'b010111);
    localparam logic [OPW-1:0] OP_SRA   = OPW'(6'b011000);
    localparam logic [OPW-1:0] OP_MULT  = OPW'(6'b011001);
    localparam logic [OPW-1:0] OP_MULTU = OPW'(6'b011010);
    localparam logic [OPW-1:0] OP_DIV   = OPW'(6'b011011);
    localparam logic [OPW-1:0] OP_DIVU  = OPW'(6'b011100);
    localparam logic [OPW-1:0] OP_MFHI  = OPW'(6'b011101);
    localparam logic [OPW-1:0] OP_MFLO  = OPW'(6'b011110);
`ifdef ALU_MTHILO_EN
    localparam logic [OPW-1:0] OP_MTHI  = OPW'(6'b011111);
    localparam logic [OPW-1:0] OP_MTLO  = OPW'(6'b100000);
`endif

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_FIX  = 2'd2
    } state_t;

    state_t state_q, state_d;

    logic [WIDTH-1:0] a, b;
    logic [WIDTH-1:0] sum, diff;
    logic             add_ovf, sub_ovf;
    logic             slt_s, slt_u;
    logic [SHW-1:0]   shamt;

    logic [WIDTH-1:0] res;
    logic             ovf;
    logic             branch;
    logic             branch_z;

    logic [WIDTH-1:0] hi_q, lo_q;
    logic             done_q;

    // shared multiply/divide registers:
    //   multiply: acc_hi = partial product high half, acc_lo = multiplier
    //             shifting out / product low half shifting in
    //   divide:   acc_hi = partial remainder, acc_lo = dividend shifting
    //             out / quotient bits shifting in
    logic [WIDTH-1:0] acc_hi_q, acc_lo_q;
    logic [WIDTH-1:0] opb_q;
    logic [CW-1:0]    count_q;
    logic             is_div_q;
    logic             neg_q_q;
    logic             neg_r_q;
    logic             dz_q;

    logic             md_op;
    logic             md_signed;
    logic             md_div;
    logic             launch;
    logic             sgn_a, sgn_b;
    logic [WIDTH-1:0] mag_a, mag_b;

    logic             mthi_we, mtlo_we;

    // ------------------------------------------------------------------
    // single-cycle datapath
    // ------------------------------------------------------------------
    assign a     = read_data1;
    assign b     = read_data2;
    assign sum   = a + b;
    assign diff  = a - b;
    assign shamt = b[SHW-1:0];
    assign slt_s = $signed(a) < $signed(b);
    assign slt_u = a < b;

    // overflow when both addends share a sign the sum does not, or when
    // the subtrahend's sign differs from A and the difference flips sign
    assign add_ovf = (a[WIDTH-1] == b[WIDTH-1]) && (sum[WIDTH-1]  != a[WIDTH-1]);
    assign sub_ovf = (a[WIDTH-1] != b[WIDTH-1]) && (diff[WIDTH-1] != a[WIDTH-1]);

    always_comb begin
        res      = '0;
        ovf      = 1'b0;
        branch   = 1'b0;
        branch_z = 1'b0;
        case (alu_control_out)
            OP_ADD, OP_ADDI: begin
                res = sum;
                ovf = add_ovf;
            end
            OP_SUB, OP_SUBI: begin
                res = diff;
                ovf = sub_ovf;
            end
            OP_AND, OP_ANDI:   res = a & b;
            OP_NOR:            res = ~(a | b);
            OP_OR, OP_ORI:     res = a | b;
            OP_SLT, OP_SLTI:   res = {{(WIDTH-1){1'b0}}, slt_s};
            OP_SLTU:           res = {{(WIDTH-1){1'b0}}, slt_u};
            OP_LH, OP_LW, OP_LB: res = sum;
            OP_LUI:            res = b << (WIDTH / 2);
            OP_SLL:            res = a << shamt;
            OP_SRL:            res = a >> shamt;
            OP_SRA:            res = $signed(a) >>> shamt;
            OP_BEQ: begin
                branch   = 1'b1;
                branch_z = (a == b);
            end
            OP_BNE: begin
                branch   = 1'b1;
                branch_z = (a != b);
            end
            OP_BGEZ: begin
                branch   = 1'b1;
                branch_z = ~a[WIDTH-1];
            end
            // reads during busy return the old value; the pipeline stalls
            OP_MFHI:           res = hi_q;
            OP_MFLO:           res = lo_q;
            default:           res = '0;
        endcase
    end

    assign ALU_result = res;
    assign overflow   = ovf;
    assign zero       = branch ? branch_z : (res == '0);

    // ------------------------------------------------------------------
    // multiply/divide launch decode
    // ------------------------------------------------------------------
    assign md_op     = (alu_control_out == OP_MULT) || (alu_control_out == OP_MULTU) ||
                       (alu_control_out == OP_DIV)  || (alu_control_out == OP_DIVU);
    assign md_signed = (alu_control_out == OP_MULT) || (alu_control_out == OP_DIV);
    assign md_div    = (alu_control_out == OP_DIV)  || (alu_control_out == OP_DIVU);
    assign launch    = (state_q == S_IDLE) && start && md_op;

    assign sgn_a = md_signed & a[WIDTH-1];
    assign sgn_b = md_signed & b[WIDTH-1];
    assign mag_a = sgn_a ? -a : a;
    assign mag_b = sgn_b ? -b : b;

`ifdef ALU_MTHILO_EN
    assign mthi_we = (state_q == S_IDLE) && (alu_control_out == OP_MTHI);
    assign mtlo_we = (state_q == S_IDLE) && (alu_control_out == OP_MTLO);
`else
    assign mthi_we = 1'b0;
    assign mtlo_we = 1'b0;
`endif

    // ------------------------------------------------------------------
    // iteration step logic
    // ------------------------------------------------------------------
    logic [WIDTH:0]     mul_sum;
    logic [WIDTH-1:0]   mul_hi_n, mul_lo_n;
    logic [WIDTH:0]     div_shift;
    logic               div_ge;
    logic [WIDTH-1:0]   div_sub;
    logic [WIDTH-1:0]   div_hi_n, div_lo_n;
    logic [2*WIDTH-1:0] prod, prod_neg;
    logic [WIDTH-1:0]   fix_hi, fix_lo;

    assign mul_sum  = acc_lo_q[0] ? ({1'b0, acc_hi_q} + {1'b0, opb_q}) : {1'b0, acc_hi_q};
    assign mul_hi_n = mul_sum[WIDTH:1];
    assign mul_lo_n = {mul_sum[0], acc_lo_q[WIDTH-1:1]};

    // restoring divide: the shifted remainder can need WIDTH+1 bits, but
    // whenever the subtraction is kept its result is below the divisor, so
    // the low WIDTH bits of a WIDTH-bit subtract are exact
    assign div_shift = {acc_hi_q, acc_lo_q[WIDTH-1]};
    assign div_ge    = div_shift >= {1'b0, opb_q};
    assign div_sub   = div_shift[WIDTH-1:0] - opb_q;
    assign div_hi_n  = div_ge ? div_sub : div_shift[WIDTH-1:0];
    assign div_lo_n  = {acc_lo_q[WIDTH-2:0], div_ge};

    assign prod     = {acc_hi_q, acc_lo_q};
    assign prod_neg = -prod;

    // divide by zero leaves |dividend| in the remainder, so the normal
    // remainder sign fix restores the original dividend into HI
    always_comb begin
        fix_hi = '0;
        fix_lo = '0;
        if (is_div_q) begin
            fix_hi = neg_r_q ? -acc_hi_q : acc_hi_q;
            if (dz_q)
                fix_lo = '1;
            else
                fix_lo = neg_q_q ? -acc_lo_q : acc_lo_q;
        end else if (neg_q_q) begin
            fix_hi = prod_neg[2*WIDTH-1:WIDTH];
            fix_lo = prod_neg[WIDTH-1:0];
        end else begin
            fix_hi = prod[2*WIDTH-1:WIDTH];
            fix_lo = prod[WIDTH-1:0];
        end
    end

    // ------------------------------------------------------------------
    // FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            state_q <= S_IDLE;
        else
            state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        busy    = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (launch)
                    state_d = S_RUN;
            end
            S_RUN: begin
                busy = 1'b1;
                if (count_q == LAST)
                    state_d = S_FIX;
            end
            S_FIX: begin
                busy    = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // multiply/divide datapath and HI/LO
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hi_q     <= '0;
            lo_q     <= '0;
            done_q   <= 1'b0;
            acc_hi_q <= '0;
            acc_lo_q <= '0;
            opb_q    <= '0;
            count_q  <= '0;
            is_div_q <= 1'b0;
            neg_q_q  <= 1'b0;
            neg_r_q  <= 1'b0;
            dz_q     <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (launch) begin
                        acc_hi_q <= '0;
                        acc_lo_q <= mag_a;
                        opb_q    <= mag_b;
                        count_q  <= '0;
                        is_div_q <= md_div;
                        neg_q_q  <= sgn_a ^ sgn_b;
                        neg_r_q  <= sgn_a;
                        dz_q     <= (b == '0);
                    end
                    if (mthi_we)
                        hi_q <= a;
                    if (mtlo_we)
                        lo_q <= a;
                end
                S_RUN: begin
                    acc_hi_q <= is_div_q ? div_hi_n : mul_hi_n;
                    acc_lo_q <= is_div_q ? div_lo_n : mul_lo_n;
                    count_q  <= count_q + CW'(1);
                end
                S_FIX: begin
                    hi_q    <= fix_hi;
                    lo_q    <= fix_lo;
                    done_q  <= 1'b1;
                    count_q <= '0;
                end
                default: ;
            endcase
        end
    end

    assign hi_out = hi_q;
    assign lo_out = lo_q;
    assign done   = done_q;

endmodule
